// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes and extends the instruction immediate to XLEN,
// registers it with a sideband tag behind a valid/ready handshake with a two-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic             sign,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_U    = 3'd6;
  localparam logic [2:0] FMT_Z    = 3'd7;

  // Raw fields at their natural widths; signed casts below do the extension to XLEN.
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;
  logic        [XLEN-1:0] ext_imm;
  logic        unused_opcode;

  assign imm_i = Instr[31:20];
  assign imm_s = {Instr[31:25], Instr[11:7]};
  assign imm_b = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign imm_j = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
  assign imm_u = {Instr[31:12], 12'd0};
  assign unused_opcode = ^Instr[6:0];

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    ext_imm = '0;
    case (ImmSrc)
      FMT_NONE: ext_imm = '0;
      FMT_R:    ext_imm = '0;
      FMT_I:    ext_imm = sign ? XLEN'(imm_i) : XLEN'(Instr[31:20]);
      FMT_S:    ext_imm = XLEN'(imm_s);
      FMT_B:    ext_imm = XLEN'(imm_b);
      FMT_J:    ext_imm = XLEN'(imm_j);
      FMT_U:    ext_imm = XLEN'(imm_u);
      FMT_Z:    ext_imm = XLEN'(Instr[19:15]);
      default:  ext_imm = '0;
    endcase
  end

  logic             out_valid_q;
  logic [XLEN-1:0]  out_imm_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_imm_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             in_ready_q;

  logic accept;
  logic out_free;
  logic to_out;
  logic to_skid;
  logic skid_valid_d;

  // The output register can take a new entry when empty or draining this edge;
  // a held skid entry always wins (in_ready is low then, so no accept competes).
  assign accept       = in_valid & in_ready_q;
  assign out_free     = ~out_valid_q | out_ready;
  assign to_out       = out_free & (skid_valid_q | accept);
  assign to_skid      = accept & ~out_free;
  assign skid_valid_d = to_skid | (skid_valid_q & ~out_free);

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
    end else if (Flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= to_out | (out_valid_q & ~out_ready);
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      if (to_out) begin
        out_imm_q <= skid_valid_q ? skid_imm_q : ext_imm;
        out_tag_q <= skid_valid_q ? skid_tag_q : in_tag;
      end
    end
  end

  // NOTE: skid payload has no reset; skid_valid_q qualifies it, so stale contents are never visible.
  always_ff @(posedge CLK) begin
    if (to_skid) begin
      skid_imm_q <= ext_imm;
      skid_tag_q <= in_tag;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared every cycle against a queue-based model, plus literal checks of known encodings.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, sign, out_ready;
  logic [31:0] instr, in_tag;
  logic [2:0]  imm_src;

  logic        ir32, ov32, ir64, ov64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .CLK(clk), .Reset(rst), .Flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .Instr(instr), .ImmSrc(imm_src), .sign(sign), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .CLK(clk), .Reset(rst), .Flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .Instr(instr), .ImmSrc(imm_src), .sign(sign), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference immediate as a signed 64-bit integer; the 32-bit view is its low half.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input logic sg);
    longint v;
    logic signed [11:0] f12;
    logic signed [12:0] f13;
    logic signed [20:0] f21;
    logic signed [31:0] f32;
    v = 0;
    case (src)
      3'd2: begin
        f12 = ins[31:20];
        v = sg ? longint'(f12) : longint'({52'd0, ins[31:20]});
      end
      3'd3: begin f12 = {ins[31:25], ins[11:7]}; v = f12; end
      3'd4: begin f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = f13; end
      3'd5: begin f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = f21; end
      3'd6: begin f32 = {ins[31:12], 12'd0}; v = f32; end
      3'd7: v = longint'({59'd0, ins[19:15]});
      default: v = 0;
    endcase
    return v;
  endfunction

  typedef struct packed {
    logic [63:0] imm;
    logic [31:0] tag;
  } ent_t;

  ent_t        q[$];
  logic [31:0] emerged[$];

  // Model: an in-order queue holding at most two entries.
  always @(posedge clk) begin : model
    bit acc;
    if (rst || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back('{imm: ref_imm(instr, imm_src, sign), tag: in_tag});
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("in_ready32", {63'd0, ir32}, {63'd0, q.size() < 2});
      check("in_ready64", {63'd0, ir64}, {63'd0, q.size() < 2});
      check("out_valid32", {63'd0, ov32}, {63'd0, q.size() > 0});
      check("out_valid64", {63'd0, ov64}, {63'd0, q.size() > 0});
      if (q.size() > 0) begin
        check("out_imm32", {32'd0, imm32}, {32'd0, q[0].imm[31:0]});
        check("out_imm64", imm64, q[0].imm);
        check("out_tag32", {32'd0, tag32}, {32'd0, q[0].tag});
        check("out_tag64", {32'd0, tag64}, {32'd0, q[0].tag});
      end
      if (ov32 && out_ready) emerged.push_back(tag32);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic v, input logic [31:0] ins, input logic [2:0] src,
                     input logic sg, input logic [31:0] tg);
    in_valid = v;
    instr    = ins;
    imm_src  = src;
    sign     = sg;
    in_tag   = tg;
  endtask

  // Hold the current input until the DUT takes it; in_ready seen now is the value at the next edge.
  task automatic wait_accept();
    int n;
    n = 0;
    while (!ir32 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'd1, 64'd0);
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    put(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_out_valid", {63'd0, ov32}, 64'd0);
    check("rst_out_imm32", {32'd0, imm32}, 64'd0);
    check("rst_out_tag32", {32'd0, tag32}, 64'd0);
    check("rst_out_imm64", imm64, 64'd0);
    rst = 1'b0;
    check("rst_in_ready", {63'd0, ir32}, 64'd1);

    // Directed formats, back-to-back with out_ready high: each result appears one cycle later.
    out_ready = 1'b1;
    put(1'b1, 32'hFFF00093, 3'd2, 1'b1, 32'h10); tick();
    check("i_sext32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
    check("i_sext64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("i_valid", {63'd0, ov32}, 64'd1);
    put(1'b1, 32'hFFF00093, 3'd2, 1'b0, 32'h11); tick();
    check("i_zext32", {32'd0, imm32}, 64'h0000_0000_0000_0FFF);
    check("i_zext64", imm64, 64'h0000_0000_0000_0FFF);
    check("i_zext_tag", {32'd0, tag32}, 64'h11);
    put(1'b1, 32'hFE000EE3, 3'd4, 1'b0, 32'h12); tick();
    check("b_beq_m4_32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
    check("b_beq_m4_64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    put(1'b1, 32'h123450B7, 3'd6, 1'b0, 32'h13); tick();
    check("u_lui32", {32'd0, imm32}, 64'h0000_0000_1234_5000);
    check("u_lui64", imm64, 64'h0000_0000_1234_5000);
    put(1'b1, 32'h000F8073, 3'd7, 1'b1, 32'h14); tick();
    check("z_uimm32", {32'd0, imm32}, 64'h1F);
    check("z_uimm64", imm64, 64'h1F);
    put(1'b1, 32'h800000B7, 3'd6, 1'b0, 32'h15); tick();
    check("u_neg32", {32'd0, imm32}, 64'h0000_0000_8000_0000);
    check("u_neg64", imm64, 64'hFFFF_FFFF_8000_0000);
    put(1'b1, 32'hFE112E23, 3'd3, 1'b0, 32'h16); tick();
    check("s_sw_m4_32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
    put(1'b1, 32'h0080006F, 3'd5, 1'b0, 32'h17); tick();
    check("j_jal8_64", imm64, 64'h8);
    put(1'b1, 32'hFFFFFFFF, 3'd0, 1'b1, 32'h18); tick();
    check("none_zero", imm64, 64'd0);
    put(1'b1, 32'hFFFFFFFF, 3'd1, 1'b1, 32'h19); tick();
    check("r_zero", imm64, 64'd0);
    put(1'b0, 32'd0, 3'd0, 1'b0, 32'd0); tick(); tick();
    check("drained", {63'd0, ov32}, 64'd0);

    // Backpressure: tags 1..4, output stalled from the second cycle.
    emerged.delete();
    put(1'b1, 32'hFFF00093, 3'd2, 1'b1, 32'd1); tick();
    out_ready = 1'b0;
    put(1'b1, 32'h123450B7, 3'd6, 1'b0, 32'd2); tick();
    check("bp_in_ready_drop", {63'd0, ir32}, 64'd0);
    check("bp_head_tag", {32'd0, tag32}, 64'd1);
    put(1'b1, 32'hFE000EE3, 3'd4, 1'b0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_tag", {32'd0, tag32}, 64'd1);
      check("bp_hold_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
    end
    out_ready = 1'b1;
    wait_accept();
    put(1'b1, 32'h000F8073, 3'd7, 1'b0, 32'd4);
    wait_accept();
    put(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    repeat (4) tick();
    check("bp_count", 64'(emerged.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < emerged.size()) check("bp_order", {32'd0, emerged[i]}, 64'(i + 1));
    end

    // Flush with both registers full; tag 9 is presented in the flush cycle.
    emerged.delete();
    out_ready = 1'b0;
    put(1'b1, 32'hFFF00093, 3'd2, 1'b1, 32'd7); tick();
    put(1'b1, 32'hFFF00093, 3'd2, 1'b1, 32'd8); tick();
    check("fl_full", {63'd0, ir32}, 64'd0);
    put(1'b1, 32'hFFF00093, 3'd2, 1'b1, 32'd9);
    flush = 1'b1; tick(); flush = 1'b0;
    put(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    check("fl_out_valid", {63'd0, ov32}, 64'd0);
    check("fl_in_ready", {63'd0, ir32}, 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("fl_nothing_out", 64'(emerged.size()), 64'd0);

    // Flush while in_ready is high: the incoming tag 9 must still be dropped.
    out_ready = 1'b0;
    put(1'b1, 32'h123450B7, 3'd6, 1'b0, 32'd5); tick();
    put(1'b1, 32'h123450B7, 3'd6, 1'b0, 32'd9);
    flush = 1'b1; tick(); flush = 1'b0;
    put(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    check("fl2_out_valid", {63'd0, ov32}, 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("fl2_nothing_out", 64'(emerged.size()), 64'd0);

    // Reset mid-stall with both registers full.
    out_ready = 1'b0;
    put(1'b1, 32'hFFF00093, 3'd2, 1'b1, 32'h21); tick();
    put(1'b1, 32'h800000B7, 3'd6, 1'b0, 32'h22); tick();
    put(1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    check("rs_stalled", {63'd0, ov32}, 64'd1);
    rst = 1'b1; tick();
    check("rs_out_valid", {63'd0, ov32}, 64'd0);
    check("rs_out_imm32", {32'd0, imm32}, 64'd0);
    check("rs_out_imm64", imm64, 64'd0);
    check("rs_out_tag", {32'd0, tag64}, 64'd0);
    rst = 1'b0;
    check("rs_in_ready", {63'd0, ir32}, 64'd1);
    tick();
    check("rs_in_ready_after", {63'd0, ir64}, 64'd1);
    check("rs_empty_after", {63'd0, ov64}, 64'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Generalises the combinational extender:
  - XLEN-wide output (RV32/RV64).
  - Adds U-type and CSR-zimm formats.
  - Carries a sideband tag (PC or ROB index) alongside each immediate.
- One-cycle registered latency, valid/ready handshake on both sides, two-entry skid buffer so ready is registered, and a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 32, sideband tag width; tag passes through unmodified.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous pipeline kill; drops all held and incoming entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept; registered.
- Instr  input  32  instruction word.
- ImmSrc  input  3  format select (encoding below).
- sign  input  1  I-type only: 1 = sign-extend, 0 = zero-extend.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  out_imm/out_tag valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag paired with out_imm.

Behaviour:
- Immediate formats by ImmSrc. Extension always fills to XLEN; "sext" means replicate Instr[31].
  - 0 none -> 0.
  - 1 R-type -> 0.
  - 2 I-type -> Instr[31:20]; sext if sign=1, else zero-extend.
  - 3 S-type -> {Instr[31:25], Instr[11:7]}; sext.
  - 4 B-type -> {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}; sext.
  - 5 J-type -> {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}; sext.
  - 6 U-type -> {Instr[31:12], 12'b0}; sext above bit 31 when XLEN=64.
  - 7 Z (CSR uimm) -> Instr[19:15]; zero-extend.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - in_valid may not depend on in_ready.
- Storage: output register plus one skid register.
  - Extension is computed before registering.
  - Latency is exactly 1 cycle from accept to out_valid when the output register is empty or draining.
- in_ready = ~skid_valid, driven from a flop.
  - Deasserts the cycle after an accept lands in the skid register.
  - Reasserts the cycle after the skid entry moves to the output register.
- Accept while output register full and not draining -> entry goes to skid register.
- Output drain with skid full -> skid moves to output register in the same edge; order is preserved.
- Simultaneous accept and drain with skid empty -> new entry loads the output register directly; out_valid stays 1 with no bubble.
- While out_valid & ~out_ready, out_imm and out_tag hold stable.
- Throughput: one entry per cycle when out_ready is held high.
- Flush (Reset not asserted):
  - Next edge clears out_valid and skid_valid.
  - in_ready reads 1 the following cycle.
  - Any input presented during the Flush cycle is dropped.
  - Data registers need not clear.
- Reset:
  - Next edge sets out_valid=0, skid_valid=0, out_imm=0, out_tag=0.
  - in_ready=1 from the first cycle after Reset deasserts.
  - Reset takes priority over Flush and over any transfer, including mid-stall.
- No illegal encodings exist; all 8 ImmSrc values are defined.

Test Plan:
- XLEN=32, ImmSrc=2, Instr=0xFFF00093, out_ready=1 -> one cycle later out_imm=0xFFFFFFFF with sign=1; out_imm=0x00000FFF with sign=0.
- ImmSrc=4, Instr=0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC. ImmSrc=6, Instr=0x123450B7 -> 0x12345000. ImmSrc=7, Instr[19:15]=5'h1F -> 0x0000001F.
- XLEN=64: ImmSrc=2, Instr=0xFFF00093, sign=1 -> 0xFFFFFFFFFFFFFFFF. ImmSrc=6, Instr=0x800000B7 -> 0xFFFFFFFF80000000.
- Backpressure: stream tags 1..4 back-to-back, hold out_ready=0 from cycle 1.
  - in_ready drops after tag 2 is accepted.
  - out_tag holds 1.
  - On releasing out_ready, tags emerge 1, 2, 3, 4 in order with no loss or duplication.
- Flush with both registers full and in_valid=1 (tag 9) -> next cycle out_valid=0, in_ready=1; tag 9 never appears.
- Reset asserted mid-stall (out_valid=1, out_ready=0) -> next cycle out_valid=0, out_imm=0, out_tag=0; in_ready=1 after Reset deasserts.
